// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash master.
// Also holds the phase sequencing helper used by the FSM.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_END,
    S_GAP
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_PAGE_PROG = 8'h02;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_RDSR      = 8'h05;

  // Phase that follows s, skipping phases with nothing to send.
  function automatic state_e next_phase(
    input state_e     s,
    input logic       aen,
    input logic [4:0] dum,
    input logic [5:0] len
  );
    state_e n;
    n = S_END;
    if (len != 6'd0 && s != S_DATA) n = S_DATA;
    if (dum != 5'd0 && (s == S_CMD || s == S_ADDR)) n = S_DUMMY;
    if (aen && s == S_CMD) n = S_ADDR;
    return n;
  endfunction

endpackage

// File: rtl/spi_flash_if.sv
// Request/response bundle between the bus adapter and the SPI master.
// The master modport is the requesting side, slave is the SPI engine.
interface spi_flash_if #(
  parameter int ADDR_W = 24
);
  logic              start;
  logic              write_enable;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic              addr_en;
  logic [4:0]        dummy_cycles;
  logic [5:0]        data_len;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, write_enable, cmd, addr, addr_en,
    output dummy_cycles, data_len, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  start, write_enable, cmd, addr, addr_en,
    input  dummy_cycles, data_len, data_in,
    output data_out, busy, done
  );
endinterface

// File: rtl/spi_flash_master_clk_gen.sv
// SPI mode-0 bit clock: low half then high half per bit.
// Strobes mark the last cycle of each half while enabled.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_o,
  output logic rise_o
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int H  = CLK_DIV / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  assign rise_o = en_i && (cnt_q == CW'(H - 1));
  assign fall_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      cnt_d  = fall_o ? '0 : cnt_q + 1'b1;
      sclk_d = (cnt_d >= CW'(H));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_flash_master.sv
// SPI mode-0 flash master: cmd, optional addr, dummy and data phases.
// Power-up delay, CS high gap and right-aligned read data.
module spi_flash_master #(
  parameter int CLK_DIV        = 4,
  parameter int ADDR_W         = 24,
  parameter int INIT_CYCLES    = 4095,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_flash_if.slave bus,
  output logic       spi_clk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  import spi_flash_pkg::*;

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int GW = $clog2(CS_HIGH_CYCLES + 1);

  state_e            state_q, state_d, nxt;
  logic [IW-1:0]     init_q, init_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [5:0]        bits_q, bits_d;
  logic [5:0]        len_q, len_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       dout_q, dout_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        dum_q, dum_d;
  logic              aen_q, aen_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              sck_en, fall, rise;

  assign sck_en = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (sck_en),
    .sclk_o(spi_clk),
    .fall_o(fall),
    .rise_o(rise)
  );

  always_comb begin
    state_d = state_q;
    nxt     = S_END;
    init_d  = init_q;
    gap_d   = gap_q;
    bits_d  = bits_q;
    len_d   = len_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    wdat_d  = wdat_q;
    addr_d  = addr_q;
    dum_d   = dum_q;
    aen_d   = aen_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      S_INIT: begin
        if (init_q == IW'(INIT_CYCLES - 1)) state_d = S_IDLE;
        else init_d = init_q + 1'b1;
      end
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CMD;
          addr_d  = bus.addr;
          aen_d   = bus.addr_en;
          dum_d   = bus.dummy_cycles;
          len_d   = (bus.data_len > 6'd32) ? 6'd32 : bus.data_len;
          wr_d    = bus.write_enable;
          wdat_d  = bus.data_in;
          tx_d    = {bus.cmd, 24'h0};
          mosi_d  = bus.cmd[7];
          bits_d  = 6'd7;
          rx_d    = '0;
          cs_d    = 1'b0;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (rise && state_q == S_DATA && !wr_q) rx_d = {rx_q[30:0], spi_miso};
        if (fall && bits_q != 6'd0) begin
          bits_d = bits_q - 6'd1;
          tx_d   = tx_q << 1;
          mosi_d = tx_q[30];
        end else if (fall) begin
          nxt     = next_phase(state_q, aen_q, dum_q, len_q);
          state_d = nxt;
          unique case (1'b1)
            nxt == S_ADDR: begin
              tx_d   = 32'(addr_q) << (32 - ADDR_W);
              bits_d = 6'(ADDR_W - 1);
              mosi_d = tx_d[31];
            end
            nxt == S_DUMMY: begin
              tx_d   = '0;
              bits_d = {1'b0, dum_q} - 6'd1;
              mosi_d = 1'b0;
            end
            nxt == S_DATA: begin
              tx_d   = wr_q ? (wdat_q << (6'd32 - len_q)) : '0;
              bits_d = len_q - 6'd1;
              mosi_d = tx_d[31];
            end
            default: begin
              cs_d   = 1'b1;
              mosi_d = 1'b0;
              done_d = 1'b1;
              if (!wr_q && len_q != 6'd0) dout_d = rx_q;
            end
          endcase
        end
      end
      S_END: begin
        // END is the first of the CS high cycles
        gap_d   = GW'(1);
        state_d = (CS_HIGH_CYCLES <= 1) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(CS_HIGH_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      init_q  <= '0;
      gap_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      wdat_q  <= '0;
      addr_q  <= '0;
      dum_q   <= '0;
      aen_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      gap_q   <= gap_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
      dum_q   <= dum_d;
      aen_q   <= aen_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign spi_cs_n     = cs_q;
  assign spi_mosi     = mosi_q;
endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- Parametrised successor of the single-mode SPI master: SPI mode-0 master for serial NOR flash and SPI peripherals, with configurable clock divider, optional address phase, programmable dummy cycles and 0..32-bit data phase.
- Sits between the memory/peripheral bus adapter and the SPI pads.
- Adds busy/ready handshake, power-up delay, guaranteed CS high time and right-aligned read data.

Parameters:
CLK_DIV, 4, sclk period in clk cycles; even, >=2
ADDR_W, 24, address phase width in bits (multiple of 8, 8..32)
INIT_CYCLES, 4095, post-reset delay before first transaction
CS_HIGH_CYCLES, 2, minimum clk cycles cs_n stays high between transactions (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
write_enable  in  1  1 = data phase drives MOSI, 0 = data phase samples MISO
cmd  in  8  command byte
addr  in  ADDR_W  address
addr_en  in  1  1 = send address phase
dummy_cycles  in  5  sclk cycles between address and data (0..31)
data_len  in  6  data bits (0..32; 0 = no data phase)
data_in  in  32  write data; data_in[data_len-1] sent first
data_out  out  32  read data, right-aligned
busy  out  1  transaction, init or CS gap in progress
done  out  1  one-cycle completion pulse
spi_clk  out  1  SPI clock, idle low
spi_cs_n  out  1  chip select, active low
spi_mosi  out  1  master out
spi_miso  in  1  master in

Behaviour:
- Reset values: data_out=0, busy=1, done=0, spi_clk=0, spi_cs_n=1, spi_mosi=0. Reset mid-transaction returns all outputs to these values immediately and restarts INIT.
- States: INIT -> IDLE -> CMD -> [ADDR if addr_en] -> [DUMMY if dummy_cycles!=0] -> [DATA if data_len!=0] -> END -> GAP -> IDLE.
- INIT: counts INIT_CYCLES clk cycles with busy=1. start during INIT is ignored.
- IDLE: busy=0. start with busy=0 at cycle T latches all inputs; busy=1 from T+1.
- Each bit is CLK_DIV clk cycles: spi_clk low for CLK_DIV/2, then high for CLK_DIV/2.
- MOSI updates at the start of each low half. MISO is sampled on the clk edge where spi_clk goes 0->1.
- Frame length in bits: N = 8 + (addr_en ? ADDR_W : 0) + dummy_cycles + data_len.
- spi_cs_n=0 and MOSI=cmd[7] at T+1. The last high half ends at T+N*CLK_DIV.
- END, at T+N*CLK_DIV+1: spi_cs_n=1, spi_clk=0, spi_mosi=0, done=1 for exactly one cycle, data_out updated the same cycle.
- Bit order is MSB first in every phase. MOSI is 0 during DUMMY and during read DATA.
- Read: data_out = zero-extended data_len-bit value, first received bit at bit data_len-1.
- Write, or data_len=0: data_out is unchanged.
- GAP: cs_n held high for CS_HIGH_CYCLES cycles including the END cycle; busy drops in the following cycle.
- start while busy=1 is ignored (not queued).
- data_len values >32 are treated as 32.
- spi_clk has no partial pulses; it is low whenever cs_n is high.

Decomposition:
- Package spi_flash_pkg: state encoding, default command constants (READ 0x03, FAST_READ 0x0B, PAGE_PROG 0x02, WREN 0x06, RDSR 0x05).
- Sub-module spi_clk_gen: half-period counter producing spi_clk, a fall strobe and a rise strobe, enabled by the FSM.
- Shift/count logic stays in the top module.

Test Plan:
1. Power-up: start pulsed at cycle 100 -> ignored, cs_n stays 1. busy falls at INIT_CYCLES+1; start then accepted.
2. READ cmd 0x03, addr 0x000100, addr_en=1, dummy 0, len 32, slave returns 0xDEADBEEF -> MOSI shows 0x03000100; data_out=0xDEADBEEF. cs_n low exactly 64*CLK_DIV cycles; single done pulse.
3. FAST_READ 0x0B, dummy 8, len 8, slave byte 0x5A -> 8 sclk pulses with MOSI=0 before data; data_out=0x0000005A.
4. PAGE_PROG 0x02, len 16, data_in=0x0000A5C3 -> MOSI bits after address = 0xA5C3. data_out unchanged; cs_n high >=CS_HIGH_CYCLES before the next transaction's cs_n falls.
5. WREN 0x06, addr_en=0, len 0 -> exactly 8 sclk pulses, cs_n low 8*CLK_DIV cycles. start re-pulsed while busy is ignored.
6. rst_n asserted mid-ADDR -> cs_n=1, spi_clk=0, busy=1 immediately. After release, INIT repeats and no done pulse occurs.
